// File: rtl/sha_msg_scheduler.sv
// sha_msg_scheduler: SHA message-schedule generator for all sha::mode_t modes.
// Loads one 16-word block and streams W_0..W_(R-1) over valid/ready.
// R = 64 for sha224/sha256 and 80 otherwise. A 16-word sliding window holds
// W_t..W_(t+15); each handshake shifts it and appends W_(t+16).
// Optional feature macro: SHA_SCHED_ABORT_EN adds abort_i.
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   start_i     load request, sampled only in IDLE
//   mode_i      sha::mode_t encoding, sampled with start_i
//   blk_i       message block, word 0 in MSBs
//   abort_i     (SHA_SCHED_ABORT_EN only) abandon the current stream
//   busy_o      high while streaming
//   w_valid_o   w_o valid; w_ready_i: consumer accepts w_o
//   w_o         schedule word W_t (32-bit modes drive upper bits 0)
//   w_idx_o     t of current w_o
//   last_o      w_valid_o && t == R-1
//   done_o      1-cycle pulse after the last handshake
//   err_o       1-cycle pulse: start_i with an unsupported mode

package sha;
  typedef enum logic [2:0] {
    SHA1       = 3'd0,
    SHA224     = 3'd1,
    SHA256     = 3'd2,
    SHA384     = 3'd3,
    SHA512     = 3'd4,
    SHA512_224 = 3'd5,
    SHA512_256 = 3'd6
  } mode_t;
endpackage

module sha_msg_scheduler #(
  parameter int unsigned WORD_W = 64,
  parameter int unsigned BLK_W  = 16 * WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [2:0]        mode_i,
  input  logic [BLK_W-1:0]  blk_i,
`ifdef SHA_SCHED_ABORT_EN
  input  logic              abort_i,
`endif
  output logic              busy_o,
  output logic              w_valid_o,
  input  logic              w_ready_i,
  output logic [WORD_W-1:0] w_o,
  output logic [6:0]        w_idx_o,
  output logic              last_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned NW = 16;

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t            state_q, state_d;
  logic [6:0]        t_q, t_d;
  logic [2:0]        mode_q, mode_d;
  logic [WORD_W-1:0] win_q [NW];
  logic [WORD_W-1:0] win_d [NW];
  logic [WORD_W-1:0] ld_win [NW];
  logic [WORD_W-1:0] nxt;
  logic              busy_q, busy_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       nxt32;
  logic [31:0]       sha1_x;
  logic              mode_ok;
  logic [6:0]        last_idx;

  function automatic logic is64(input logic [2:0] m);
    return (m == sha::SHA384) || (m == sha::SHA512) ||
           (m == sha::SHA512_224) || (m == sha::SHA512_256);
  endfunction

  function automatic logic [31:0] s0_32(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1_32(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [63:0] s0_64(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction

  function automatic logic [63:0] s1_64(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

  // 64-bit modes only exist in the wide build
  assign mode_ok  = (mode_i != 3'b111) && ((WORD_W == 32'd64) || !is64(mode_i));
  assign last_idx = ((mode_q == sha::SHA224) || (mode_q == sha::SHA256)) ? 7'd63 : 7'd79;

  // 32-bit next word, shared by sha1 and sha224/256 (low word lanes)
  always_comb begin
    sha1_x = win_q[13][31:0] ^ win_q[8][31:0] ^ win_q[2][31:0] ^ win_q[0][31:0];
    if (mode_q == sha::SHA1) begin
      nxt32 = {sha1_x[30:0], sha1_x[31]};
    end else begin
      nxt32 = s1_32(win_q[14][31:0]) + win_q[9][31:0] + s0_32(win_q[1][31:0]) + win_q[0][31:0];
    end
  end

  // Block unpacking and next-word select depend on the supported word width
  generate
    if (WORD_W == 32'd64) begin : g_w64
      always_comb begin
        for (int unsigned k = 0; k < NW; k++) begin
          ld_win[k] = is64(mode_i) ? blk_i[1023-64*k -: 64] : 64'(blk_i[511-32*k -: 32]);
        end
        nxt = is64(mode_q) ? s1_64(win_q[14]) + win_q[9] + s0_64(win_q[1]) + win_q[0]
                           : 64'(nxt32);
      end
    end else begin : g_w32
      always_comb begin
        for (int unsigned k = 0; k < NW; k++) begin
          ld_win[k] = blk_i[511-32*k -: 32];
        end
        nxt = nxt32;
      end
    end
  endgenerate

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    mode_d  = mode_q;
    win_d   = win_q;
    busy_d  = busy_q;
    last_d  = last_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // start_i in the done cycle is ignored
        if (start_i && !done_q) begin
          if (mode_ok) begin
            state_d = S_STREAM;
            mode_d  = mode_i;
            win_d   = ld_win;
            t_d     = 7'd0;
            busy_d  = 1'b1;
            last_d  = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_STREAM: begin
`ifdef SHA_SCHED_ABORT_EN
        if (abort_i) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          last_d  = 1'b0;
        end else
`endif
        if (w_ready_i) begin
          for (int unsigned k = 0; k < NW - 1; k++) begin
            win_d[k] = win_q[k+1];
          end
          win_d[NW-1] = nxt;
          t_d = t_q + 7'd1;
          if (t_q == last_idx) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            last_d = ((t_q + 7'd1) == last_idx);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      t_q     <= 7'd0;
      mode_q  <= 3'd0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned k = 0; k < NW; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
      win_q   <= win_d;
    end
  end

  assign busy_o    = busy_q;
  assign w_valid_o = busy_q;
  assign w_o       = win_q[0];
  assign w_idx_o   = t_q;
  assign last_o    = last_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_sha_msg_scheduler.sv
// Bench for sha_msg_scheduler: random and known-answer streams checked
// against a direct FIPS-180 style schedule model, plus error/reset paths.
module tb_sha_msg_scheduler;
  import sha::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Wide (64-bit) instance
  logic          start_i;
  logic [2:0]    mode_i;
  logic [1023:0] blk_i;
  logic          w_ready_i;
  logic          busy_o, w_valid_o, last_o, done_o, err_o;
  logic [63:0]   w_o;
  logic [6:0]    w_idx_o;
`ifdef SHA_SCHED_ABORT_EN
  logic          abort_i;
  logic          s_abort;
`endif

  // Narrow (32-bit) instance
  logic          s_start, s_ready;
  logic [2:0]    s_mode;
  logic [511:0]  s_blk;
  logic          s_busy, s_valid, s_last, s_done, s_err;
  logic [31:0]   s_w;
  logic [6:0]    s_idx;

  sha_msg_scheduler #(.WORD_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i), .blk_i(blk_i),
`ifdef SHA_SCHED_ABORT_EN
    .abort_i(abort_i),
`endif
    .busy_o(busy_o), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_o(w_o),
    .w_idx_o(w_idx_o), .last_o(last_o), .done_o(done_o), .err_o(err_o)
  );

  sha_msg_scheduler #(.WORD_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start_i(s_start), .mode_i(s_mode), .blk_i(s_blk),
`ifdef SHA_SCHED_ABORT_EN
    .abort_i(s_abort),
`endif
    .busy_o(s_busy), .w_valid_o(s_valid), .w_ready_i(s_ready), .w_o(s_w),
    .w_idx_o(s_idx), .last_o(s_last), .done_o(s_done), .err_o(s_err)
  );

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_w [80];
  logic [63:0] got   [80];
  int          exp_r;

  function automatic logic [31:0] rr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [63:0] rr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference schedule: W_t recurrence over the whole message, no window
  task automatic build_exp(input logic [2:0] m, input logic [1023:0] b);
    logic        wide;
    logic [31:0] x, a, c;
    logic [63:0] y, p, q;
    wide  = (m >= 3'd3) && (m <= 3'd6);
    exp_r = (m == SHA224 || m == SHA256) ? 64 : 80;
    for (int i = 0; i < 16; i++)
      exp_w[i] = wide ? b[1023-64*i -: 64] : {32'b0, b[511-32*i -: 32]};
    for (int i = 16; i < 80; i++) begin
      if (m == SHA1) begin
        x = exp_w[i-3][31:0] ^ exp_w[i-8][31:0] ^ exp_w[i-14][31:0] ^ exp_w[i-16][31:0];
        exp_w[i] = {32'b0, rr32(x, 31)};
      end else if (!wide) begin
        a = exp_w[i-2][31:0];
        c = exp_w[i-15][31:0];
        x = (rr32(a, 17) ^ rr32(a, 19) ^ (a >> 10)) + exp_w[i-7][31:0]
          + (rr32(c, 7) ^ rr32(c, 18) ^ (c >> 3)) + exp_w[i-16][31:0];
        exp_w[i] = {32'b0, x};
      end else begin
        p = exp_w[i-2];
        q = exp_w[i-15];
        y = (rr64(p, 19) ^ rr64(p, 61) ^ (p >> 6)) + exp_w[i-7]
          + (rr64(q, 1) ^ rr64(q, 8) ^ (q >> 7)) + exp_w[i-16];
        exp_w[i] = y;
      end
    end
  endtask

  // Start a stream and consume words; stop_at<0 runs to completion
  task automatic run_stream(input logic [2:0] m, input logic [1023:0] b, input int ready_pct,
                            input int inject_at, input int stop_at, output int consumed);
    int   n;
    int   cyc;
    logic rdy;
    logic exp_last;
    n = 0;
    cyc = 0;
    build_exp(m, b);
    @(negedge clk);
    start_i = 1'b1; mode_i = m; blk_i = b; w_ready_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    while (n < exp_r && (stop_at < 0 || n < stop_at) && cyc < 2000) begin
      cyc++;
      exp_last = (n == exp_r - 1);
      checks++;
      if (w_valid_o !== 1'b1 || busy_o !== 1'b1)
        $display("FAIL valid t=%0d got v=%b b=%b exp 1", n, w_valid_o, busy_o);
      if (w_valid_o !== 1'b1 || busy_o !== 1'b1) errors++;
      checks++;
      if (w_o !== exp_w[n]) begin
        errors++;
        $display("FAIL w_o mode=%0d t=%0d got=%h exp=%h", m, n, w_o, exp_w[n]);
      end
      checks++;
      if (w_idx_o !== 7'(n)) begin
        errors++;
        $display("FAIL w_idx got=%0d exp=%0d", w_idx_o, n);
      end
      checks++;
      if (last_o !== exp_last) begin
        errors++;
        $display("FAIL last_o t=%0d got=%b exp=%b", n, last_o, exp_last);
      end
      checks++;
      if (err_o !== 1'b0 || done_o !== 1'b0) begin
        errors++;
        $display("FAIL err/done mid-stream t=%0d got err=%b done=%b exp 0", n, err_o, done_o);
      end
      got[n]  = w_o;
      start_i = (n == inject_at);
      mode_i  = 3'b111;
      rdy = ($urandom_range(99) < 32'(ready_pct));
      w_ready_i = rdy;
      if (rdy) n++;
      @(negedge clk);
    end
    start_i = 1'b0;
    w_ready_i = 1'b0;
    consumed = n;
    if (cyc >= 2000) begin
      errors++;
      checks++;
      $display("FAIL timeout words got=%0d exp=%0d", n, exp_r);
    end else if (n == exp_r) begin
      checks++;
      if (done_o !== 1'b1 || w_valid_o !== 1'b0 || busy_o !== 1'b0 || last_o !== 1'b0) begin
        errors++;
        $display("FAIL done cycle got done=%b v=%b b=%b l=%b exp 1000", done_o, w_valid_o, busy_o, last_o);
      end
      // start in the done cycle must be ignored
      start_i = 1'b1; mode_i = SHA256;
      @(negedge clk);
      start_i = 1'b0;
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0) begin
        errors++;
        $display("FAIL after done got done=%b b=%b err=%b exp 000", done_o, busy_o, err_o);
      end
    end
  endtask

  function automatic logic [1023:0] abc32();
    logic [1023:0] b;
    b = '0;
    b[511:480] = 32'h61626380;
    b[31:0]    = 32'h00000018;
    return b;
  endfunction

  function automatic logic [1023:0] abc64();
    logic [1023:0] b;
    b = '0;
    b[1023:960] = 64'h6162638000000000;
    b[63:0]     = 64'h18;
    return b;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    start_i = 0; mode_i = 0; blk_i = '0; w_ready_i = 0;
    s_start = 0; s_mode = 0; s_blk = '0; s_ready = 0;
`ifdef SHA_SCHED_ABORT_EN
    abort_i = 0; s_abort = 0;
`endif
    #1;
    checks++;
    if ({busy_o, w_valid_o, last_o, done_o, err_o} !== 5'b0 || w_o !== 64'h0 || w_idx_o !== 7'd0) begin
      errors++;
      $display("FAIL reset outputs got=%b w=%h idx=%0d exp 0", {busy_o, w_valid_o, last_o, done_o, err_o}, w_o, w_idx_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy_o, w_valid_o, done_o, err_o, s_busy, s_err} !== 6'b0) begin
      errors++;
      $display("FAIL idle after reset got=%b exp 0", {busy_o, w_valid_o, done_o, err_o, s_busy, s_err});
    end
  endtask

  task automatic test_sha256_abc();
    int n;
    run_stream(SHA256, abc32(), 100, -1, -1, n);
    checks++;
    if (n !== 64 || got[16] !== 64'h61626380 || got[17] !== 64'h000F0000) begin
      errors++;
      $display("FAIL sha256 abc n=%0d W16=%h W17=%h exp 64 61626380 000f0000", n, got[16], got[17]);
    end
  endtask

  task automatic test_sha1_abc();
    int n;
    run_stream(SHA1, abc32(), 100, -1, -1, n);
    checks++;
    if (n !== 80 || got[16] !== 64'hC2C4C700) begin
      errors++;
      $display("FAIL sha1 abc n=%0d W16=%h exp 80 c2c4c700", n, got[16]);
    end
  endtask

  task automatic test_sha512_abc();
    int n;
    run_stream(SHA512, abc64(), 100, -1, -1, n);
    checks++;
    if (n !== 80 || got[16] !== 64'h6162638000000000) begin
      errors++;
      $display("FAIL sha512 abc n=%0d W16=%h exp 80 6162638000000000", n, got[16]);
    end
  endtask

  task automatic test_backpressure();
    int n;
    run_stream(SHA256, abc32(), 50, -1, -1, n);
    checks++;
    if (got[17] !== 64'h000F0000) begin
      errors++;
      $display("FAIL stalled W17 got=%h exp 000f0000", got[17]);
    end
  endtask

  task automatic test_random();
    logic [1023:0] b;
    logic [2:0]    m;
    int            n;
    for (int it = 0; it < 7; it++) begin
      for (int k = 0; k < 32; k++) b[k*32 +: 32] = $urandom;
      m = 3'(it);
      run_stream(m, b, 70, -1, -1, n);
    end
  endtask

  task automatic test_unsupported();
    int n;
    @(negedge clk);
    start_i = 1'b1; mode_i = 3'b111;
    s_start = 1'b1; s_mode = SHA512;
    @(negedge clk);
    start_i = 1'b0; s_start = 1'b0;
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0 || w_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL err mode7 got err=%b b=%b v=%b exp 100", err_o, busy_o, w_valid_o);
    end
    checks++;
    if (s_err !== 1'b1 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL err sha512 on 32-bit got err=%b b=%b exp 10", s_err, s_busy);
    end
    @(negedge clk);
    checks++;
    if (err_o !== 1'b0 || s_err !== 1'b0 || busy_o !== 1'b0 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL err pulse width got err=%b s_err=%b exp 00", err_o, s_err);
    end
    // start with a bad mode at t=10 in STREAM is ignored, stream continues
    run_stream(SHA256, abc32(), 100, 10, -1, n);
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL inject stream words got=%0d exp 64", n);
    end
  endtask

  task automatic test_narrow_sha256();
    int n;
    int cyc;
    build_exp(SHA256, abc32());
    @(negedge clk);
    s_start = 1'b1; s_mode = SHA256; s_blk = 512'(abc32()); s_ready = 1'b0;
    @(negedge clk);
    s_start = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 64 && cyc < 200) begin
      cyc++;
      checks++;
      if (s_valid !== 1'b1 || s_w !== exp_w[n][31:0] || s_idx !== 7'(n) || s_last !== (n == 63)) begin
        errors++;
        $display("FAIL narrow t=%0d got v=%b w=%h idx=%0d l=%b exp w=%h", n, s_valid, s_w, s_idx, s_last, exp_w[n][31:0]);
      end
      s_ready = 1'b1;
      n++;
      @(negedge clk);
    end
    s_ready = 1'b0;
    checks++;
    if (s_done !== 1'b1 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL narrow done got done=%b v=%b exp 10", s_done, s_valid);
    end
  endtask

  task automatic test_reset_mid_stream();
    int n;
    run_stream(SHA256, abc32(), 100, -1, 20, n);
    checks++;
    if (w_idx_o !== 7'd20 || w_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL pre-reset got idx=%0d v=%b exp 20 1", w_idx_o, w_valid_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_o, w_valid_o, last_o, done_o, err_o} !== 5'b0 || w_o !== 64'h0 || w_idx_o !== 7'd0) begin
      errors++;
      $display("FAIL async reset got=%b w=%h idx=%0d exp 0", {busy_o, w_valid_o, last_o, done_o, err_o}, w_o, w_idx_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL post-reset got done=%b b=%b exp 00", done_o, busy_o);
    end
    run_stream(SHA256, abc32(), 100, -1, -1, n);
    checks++;
    if (n !== 64 || got[0] !== 64'h61626380) begin
      errors++;
      $display("FAIL restart n=%0d W0=%h exp 64 61626380", n, got[0]);
    end
  endtask

`ifdef SHA_SCHED_ABORT_EN
  task automatic test_abort();
    int n;
    run_stream(SHA512, abc64(), 100, -1, 5, n);
    abort_i = 1'b1;
    w_ready_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    w_ready_i = 1'b0;
    checks++;
    if (w_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || w_idx_o !== 7'd5) begin
      errors++;
      $display("FAIL abort got v=%b b=%b done=%b idx=%0d exp 0 0 0 5", w_valid_o, busy_o, done_o, w_idx_o);
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort tail got done=%b b=%b exp 00", done_o, busy_o);
    end
  endtask
`endif

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sha256_abc();
    test_sha1_abc();
    test_sha512_abc();
    test_backpressure();
    test_random();
    test_unsupported();
    test_narrow_sha256();
`ifdef SHA_SCHED_ABORT_EN
    test_abort();
`endif
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
